dp_ram_ctrl: RTL and testbench
==============================

# dp_ram_ctrl

Parametrised simple dual-port RAM (one write port, one read port) that succeeds the fixed 8×16 scratch memory in the datapath. Adds per-byte write enables, a selectable read-during-write collision mode, an optional output pipeline register, and a post-reset clearing sequencer. Storage contents are defined after reset, and every returned read is qualified by a valid strobe.

## Interface
- `DATA_W`, default 8: word width in bits; must be a multiple of 8.
- `DEPTH`, default 32: number of words; need not be a power of two.
- `ADDR_W`, default 5: address width; must satisfy `2**ADDR_W >= DEPTH`.
- `RD_MODE`, default 0: read/write collision mode. 0 = read-first (old data), 1 = write-first (new data).
- `OUT_REG`, default 0: 1 adds an output register stage.
- `CLEAR_ON_RST`, default 1: 1 zero-fills the memory after reset.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `enb` in 1: global enable; when low, no read or write is accepted.
- `wr` in 1: write request.
- `rd` in 1: read request.
- `w_addr` in `ADDR_W`: write address.
- `r_addr` in `ADDR_W`: read address.
- `w_data` in `DATA_W`: write data.
- `w_be` in `DATA_W/8`: byte enables; bit k enables write of `w_data[8k+7:8k]`.
- `r_data` out `DATA_W`: read data.
- `r_valid` out 1: one-cycle strobe marking `r_data` valid.
- `busy` out 1: clear sequence in progress; requests are ignored while high.
- `addr_err` out 1: one-cycle pulse when an accepted request addresses `>= DEPTH`.

## Operation
- FSM states are `CLEAR` and `READY`.
- Reset (`rst == 0` at an edge) causes:
  - state becomes `CLEAR` if `CLEAR_ON_RST == 1`, else `READY`;
  - clear counter cleared to 0;
  - `r_data`, `r_valid`, `addr_err` and all pipeline registers cleared to 0.
- `CLEAR`:
  - each cycle writes 0 to `mem[cnt]` and increments `cnt`;
  - after writing `DEPTH-1`, transitions to `READY`;
  - `busy = 1` throughout; `wr`, `rd` and `enb` are ignored, with no strobes and no `addr_err`.
- `READY`: `busy = 0`.
  - Write is accepted when `enb & wr`: for each k with `w_be[k] == 1`, `mem[w_addr]` byte k takes `w_data` byte k; other bytes hold.
  - Read is accepted when `enb & rd`: `r_data` returns `mem[r_addr]` and `r_valid` pulses.
- Collision: `wr` and `rd` accepted in the same cycle with `w_addr == r_addr`.
  - `RD_MODE == 0`: the read returns the pre-write word.
  - `RD_MODE == 1`: the read returns the merged word, i.e. bytes with `w_be` set come from `w_data` and the rest from memory.
- Out-of-range address (`>= DEPTH`):
  - write is dropped and memory is unchanged;
  - read returns 0 with `r_valid` still pulsed;
  - `addr_err` pulses once per offending cycle, including when both ports are out of range.
- `wr` with `w_be == 0`: the write is accepted but memory is unchanged.
- `enb` low, or neither `rd` nor `wr`: memory holds; `r_data` holds its last value; `r_valid` stays 0.
- Reset asserted mid-clear or mid-pipeline:
  - the sequence restarts at address 0;
  - in-flight reads are discarded, and no `r_valid` appears for them.

## Timing
- Read latency from the accepting edge to `r_valid`/`r_data`:
  - 1 cycle with `OUT_REG = 0`;
  - 2 cycles with `OUT_REG = 1`.
- The pipeline always advances; there is no backpressure.
- `addr_err` follows the same latency as `r_valid`.
- Write data is visible to a read accepted on the next edge.
- Clear duration: `busy` is high for exactly `DEPTH` cycles after the first edge with `rst == 1`. The first request is accepted on the edge where `busy` is sampled 0.
- Throughput: one read and one write per cycle.

## Structure
- Package `dp_ram_pkg` holds:
  - FSM state typedef (`CLEAR`, `READY`);
  - `RD_MODE` constants `RD_FIRST = 0`, `WR_FIRST = 1`;
  - a byte-merge helper function shared with the collision bypass.
- Sub-module `dp_ram_clear_seq` holds the FSM and counter and outputs `busy`, `clr_we` and `clr_addr`.
- The top level muxes the clear port onto the write port, and holds the storage array, the bypass and the output pipeline.

## Test plan
- Reset, then idle: `busy` is high for exactly 32 cycles. Reads of addresses 0–31 then return `8'h00` with `r_valid` at latency 1 (and at latency 2 with `OUT_REG = 1`).
- Byte enables (`DATA_W = 32`): write `32'hAABBCCDD` with `w_be = 4'b1111` to address 5, then `32'h11223344` with `w_be = 4'b0101`. A read of address 5 returns `32'hAA22CC44`.
- Collision at address 3, holding 8'h55, with a same-cycle write of 8'h9A:
  - `RD_MODE = 0` returns 8'h55;
  - `RD_MODE = 1` returns 8'h9A;
  - in both modes a following read returns 8'h9A.
- `DEPTH = 20`:
  - write to address 25 leaves memory unchanged and pulses `addr_err`;
  - read from address 25 returns 0 with `r_valid` and `addr_err` both pulsing;
  - `wr` and `rd` both accepted in one cycle, both out of range: exactly one `addr_err` pulse.
- `rd` issued during `CLEAR`, or with `enb = 0`: no `r_valid`, memory unchanged.
- `rst` pulsed low at clear count 10: the clear restarts and `busy` stays high for 32 more cycles. A read in flight when reset is asserted produces no `r_valid`.

Source files
------------

// File: rtl/dp_ram_pkg.sv
// Shared types, constants and helpers for the dual-port RAM controller.
package dp_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int unsigned RD_FIRST = 0;
  localparam int unsigned WR_FIRST = 1;

  // Select the new byte when its enable is set, otherwise keep the old one.
  function automatic logic [7:0] byte_merge(input logic [7:0] i_old,
                                            input logic [7:0] i_new,
                                            input logic       i_sel);
    return i_sel ? i_new : i_old;
  endfunction

endpackage

// File: rtl/dp_ram_clear_seq.sv
// Post-reset clearing sequencer: walks every address once, then idles in READY.
module dp_ram_clear_seq
  import dp_ram_pkg::*;
#(
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned CLEAR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;

  // State and clear counter; leaves CLEAR after the last word is zeroed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= (CLEAR_ON_RST != 0) ? CLEAR : READY;
      r_cnt   <= '0;
    end else if (r_state == CLEAR) begin
      if (r_cnt == ADDR_W'(DEPTH - 1)) begin
        r_state <= READY;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + ADDR_W'(1);
      end
    end
  end

  assign busy     = (r_state == CLEAR);
  assign clr_we   = (r_state == CLEAR);
  assign clr_addr = r_cnt;

endmodule

// File: rtl/dp_ram_ctrl.sv
// Simple dual-port RAM with byte enables, collision bypass, optional output
// register and a post-reset clear sequence.
module dp_ram_ctrl
  import dp_ram_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned RD_MODE      = 0,
  parameter int unsigned OUT_REG      = 0,
  parameter int unsigned CLEAR_ON_RST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enb,
  input  logic                wr,
  input  logic                rd,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [ADDR_W-1:0]   r_addr,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_be,
  output logic [DATA_W-1:0]   r_data,
  output logic                r_valid,
  output logic                busy,
  output logic                addr_err
);

  localparam int unsigned NB      = DATA_W / 8;
  localparam bit          WR_THRU = (RD_MODE != RD_FIRST);

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;

  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_wr_oob;
  logic              w_rd_oob;
  logic              w_byp_en;
  logic              w_err;

  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;
  logic [NB-1:0]     w_mem_be;
  logic [DATA_W-1:0] w_rd_word;
  logic [DATA_W-1:0] w_rd_res;

  logic              w_s_valid;
  logic              w_s_err;
  logic [DATA_W-1:0] w_s_data;

  logic              r_vld;
  logic              r_err;
  logic [DATA_W-1:0] r_dout;

  dp_ram_clear_seq #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .CLEAR_ON_RST(CLEAR_ON_RST)
  ) u_clear_seq (
    .clk     (clk),
    .rst     (rst),
    .busy    (w_busy),
    .clr_we  (w_clr_we),
    .clr_addr(w_clr_addr)
  );

  // Request qualification; nothing is accepted while clearing.
  assign w_wr_ok  = ~w_busy & enb & wr;
  assign w_rd_ok  = ~w_busy & enb & rd;
  assign w_wr_oob = 32'(w_addr) >= DEPTH;
  assign w_rd_oob = 32'(r_addr) >= DEPTH;
  assign w_err    = (w_wr_ok & w_wr_oob) | (w_rd_ok & w_rd_oob);
  assign w_byp_en = WR_THRU & w_wr_ok & w_rd_ok & ~w_wr_oob & (w_addr == r_addr);

  // Clear port takes over the write port while busy.
  assign w_mem_we   = w_clr_we | (w_wr_ok & ~w_wr_oob);
  assign w_mem_addr = w_clr_we ? w_clr_addr : w_addr;
  assign w_mem_data = w_clr_we ? '0 : w_data;
  assign w_mem_be   = w_clr_we ? '1 : w_be;

  // One storage bank per byte lane so each lane's enable is independent.
  for (genvar g = 0; g < NB; g++) begin : g_bank
    logic [7:0] r_bank [DEPTH];

    // Byte-lane write.
    always_ff @(posedge clk) begin
      if (w_mem_we && w_mem_be[g]) begin
        r_bank[w_mem_addr] <= w_mem_data[8*g +: 8];
      end
    end

    assign w_rd_word[8*g +: 8] = byte_merge(r_bank[r_addr], w_data[8*g +: 8],
                                            w_byp_en & w_be[g]);
  end

  assign w_rd_res = w_rd_oob ? '0 : w_rd_word;

  if (OUT_REG != 0) begin : g_oreg
    logic              r_p_vld;
    logic              r_p_err;
    logic [DATA_W-1:0] r_p_data;

    // Extra pipeline stage ahead of the output register.
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_p_vld  <= 1'b0;
        r_p_err  <= 1'b0;
        r_p_data <= '0;
      end else begin
        r_p_vld  <= w_rd_ok;
        r_p_err  <= w_err;
        r_p_data <= w_rd_res;
      end
    end

    assign w_s_valid = r_p_vld;
    assign w_s_err   = r_p_err;
    assign w_s_data  = r_p_data;
  end else begin : g_noreg
    assign w_s_valid = w_rd_ok;
    assign w_s_err   = w_err;
    assign w_s_data  = w_rd_res;
  end

  // Output register: strobes every cycle, data held between valid reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld  <= 1'b0;
      r_err  <= 1'b0;
      r_dout <= '0;
    end else begin
      r_vld <= w_s_valid;
      r_err <= w_s_err;
      if (w_s_valid) begin
        r_dout <= w_s_data;
      end
    end
  end

  assign r_data   = r_dout;
  assign r_valid  = r_vld;
  assign addr_err = r_err;
  assign busy     = w_busy;

endmodule

// File: tb/tb_dp_ram_ctrl.sv
// Bench for dp_ram_ctrl: four configurations share one stimulus stream and are
// compared every cycle against a word-level reference model.
module tb_dp_ram_ctrl;

  // Instance configurations: a, b, c, d
  localparam int DW_P   [4] = '{8, 8, 32, 8};
  localparam int DEPTH_P[4] = '{32, 32, 20, 20};
  localparam int RDM_P  [4] = '{0, 1, 0, 1};
  localparam int OREG_P [4] = '{0, 1, 1, 0};

  logic        clk;
  logic        rst;
  logic        enb;
  logic        wr;
  logic        rd;
  logic [4:0]  w_addr;
  logic [4:0]  r_addr;
  logic [31:0] w_data;
  logic [3:0]  w_be;

  logic [7:0]  rdata_a, rdata_b, rdata_d;
  logic [31:0] rdata_c;
  logic        rvalid_a, rvalid_b, rvalid_c, rvalid_d;
  logic        busy_a, busy_b, busy_c, busy_d;
  logic        err_a, err_b, err_c, err_d;

  logic [31:0] act_d[4];
  logic        act_v[4];
  logic        act_b[4];
  logic        act_e[4];

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  // Reference model state
  logic [31:0] mem[4][32];
  int          clr_left[4];
  logic        pv[4], pe[4], ev[4], ee[4];
  logic [31:0] pd[4], ed[4];

  dp_ram_ctrl #(.DATA_W(8), .DEPTH(32), .ADDR_W(5), .RD_MODE(0), .OUT_REG(0), .CLEAR_ON_RST(1)) u_a (
    .clk(clk), .rst(rst), .enb(enb), .wr(wr), .rd(rd), .w_addr(w_addr), .r_addr(r_addr),
    .w_data(w_data[7:0]), .w_be(w_be[0:0]), .r_data(rdata_a), .r_valid(rvalid_a),
    .busy(busy_a), .addr_err(err_a));

  dp_ram_ctrl #(.DATA_W(8), .DEPTH(32), .ADDR_W(5), .RD_MODE(1), .OUT_REG(1), .CLEAR_ON_RST(1)) u_b (
    .clk(clk), .rst(rst), .enb(enb), .wr(wr), .rd(rd), .w_addr(w_addr), .r_addr(r_addr),
    .w_data(w_data[7:0]), .w_be(w_be[0:0]), .r_data(rdata_b), .r_valid(rvalid_b),
    .busy(busy_b), .addr_err(err_b));

  dp_ram_ctrl #(.DATA_W(32), .DEPTH(20), .ADDR_W(5), .RD_MODE(0), .OUT_REG(1), .CLEAR_ON_RST(1)) u_c (
    .clk(clk), .rst(rst), .enb(enb), .wr(wr), .rd(rd), .w_addr(w_addr), .r_addr(r_addr),
    .w_data(w_data), .w_be(w_be), .r_data(rdata_c), .r_valid(rvalid_c),
    .busy(busy_c), .addr_err(err_c));

  dp_ram_ctrl #(.DATA_W(8), .DEPTH(20), .ADDR_W(5), .RD_MODE(1), .OUT_REG(0), .CLEAR_ON_RST(1)) u_d (
    .clk(clk), .rst(rst), .enb(enb), .wr(wr), .rd(rd), .w_addr(w_addr), .r_addr(r_addr),
    .w_data(w_data[7:0]), .w_be(w_be[0:0]), .r_data(rdata_d), .r_valid(rvalid_d),
    .busy(busy_d), .addr_err(err_d));

  assign act_d[0] = {24'b0, rdata_a};
  assign act_d[1] = {24'b0, rdata_b};
  assign act_d[2] = rdata_c;
  assign act_d[3] = {24'b0, rdata_d};
  assign act_v[0] = rvalid_a;
  assign act_v[1] = rvalid_b;
  assign act_v[2] = rvalid_c;
  assign act_v[3] = rvalid_d;
  assign act_b[0] = busy_a;
  assign act_b[1] = busy_b;
  assign act_b[2] = busy_c;
  assign act_b[3] = busy_d;
  assign act_e[0] = err_a;
  assign act_e[1] = err_b;
  assign act_e[2] = err_c;
  assign act_e[3] = err_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: word-level memory, clear countdown and a latency line.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      logic [31:0] nd, nw, sd;
      logic        nv, ne, sv, se;
      if (!rst) begin
        clr_left[i] = DEPTH_P[i];
        pv[i] = 1'b0; pe[i] = 1'b0; pd[i] = '0;
        ev[i] = 1'b0; ee[i] = 1'b0; ed[i] = '0;
      end else begin
        nv = 1'b0; ne = 1'b0; nd = '0;
        if (clr_left[i] > 0) begin
          mem[i][DEPTH_P[i] - clr_left[i]] = '0;
          clr_left[i]--;
        end else begin
          if (enb && rd) begin
            nv = 1'b1;
            if (int'(r_addr) < DEPTH_P[i]) nd = mem[i][r_addr];
            else ne = 1'b1;
          end
          if (enb && wr) begin
            if (int'(w_addr) >= DEPTH_P[i]) ne = 1'b1;
            else begin
              nw = mem[i][w_addr];
              for (int k = 0; k < DW_P[i] / 8; k++)
                if (w_be[k]) nw[8*k +: 8] = w_data[8*k +: 8];
              if (RDM_P[i] == 1 && rd && r_addr == w_addr) nd = nw;
              mem[i][w_addr] = nw;
            end
          end
        end
        if (OREG_P[i] == 1) begin
          sv = pv[i]; sd = pd[i]; se = pe[i];
          pv[i] = nv; pd[i] = nd; pe[i] = ne;
        end else begin
          sv = nv; sd = nd; se = ne;
        end
        ev[i] = sv;
        ee[i] = se;
        if (sv) ed[i] = sd;
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("busy%0d", i),   32'(act_b[i]), 32'(clr_left[i] > 0));
        check($sformatf("rvalid%0d", i), 32'(act_v[i]), 32'(ev[i]));
        check($sformatf("addrerr%0d", i), 32'(act_e[i]), 32'(ee[i]));
        check($sformatf("rdata%0d", i),  act_d[i], ed[i]);
      end
    end
  end

  task automatic op(input logic iw, input logic ir, input logic [4:0] wa, input logic [4:0] ra,
                    input logic [31:0] wd, input logic [3:0] be);
    wr = iw; rd = ir; w_addr = wa; r_addr = ra; w_data = wd; w_be = be;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  // Counts busy cycles of instances a and c from the current negedge.
  task automatic count_busy(output int na, output int nc);
    int guard;
    na = 0; nc = 0; guard = 0;
    while ((busy_a || busy_c) && guard < 200) begin
      if (busy_a) na++;
      if (busy_c) nc++;
      @(negedge clk);
      guard++;
    end
  endtask

  initial begin
    int na, nc;
    rst = 1'b0; enb = 1'b1; wr = 1'b0; rd = 1'b0;
    w_addr = '0; r_addr = '0; w_data = '0; w_be = '0;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    check("reset_rvalid_a", 32'(rvalid_a), 32'd0);
    check("reset_rdata_c", rdata_c, 32'd0);
    rst = 1'b1;

    count_busy(na, nc);
    check("busy_len_32", na, 32);
    check("busy_len_20", nc, 20);

    // Every address reads back zero after the clear
    for (int i = 0; i < 32; i++) op(1'b0, 1'b1, 5'd0, 5'(i), 32'd0, 4'd0);
    check("zero_rd_a_valid", 32'(rvalid_a), 32'd1);
    check("zero_rd_a_data", {24'b0, rdata_a}, 32'd0);
    idle();
    check("zero_rd_b_valid_lat2", 32'(rvalid_b), 32'd1);
    check("zero_rd_b_data", {24'b0, rdata_b}, 32'd0);

    // Byte enables on the 32-bit instance
    op(1'b1, 1'b0, 5'd5, 5'd0, 32'hAABBCCDD, 4'b1111);
    op(1'b1, 1'b0, 5'd5, 5'd0, 32'h11223344, 4'b0101);
    op(1'b0, 1'b1, 5'd0, 5'd5, 32'd0, 4'd0);
    idle();
    check("byte_en_c", rdata_c, 32'hAA22CC44);

    // Read/write collision at address 3
    op(1'b1, 1'b0, 5'd3, 5'd0, 32'h55, 4'b0001);
    op(1'b1, 1'b1, 5'd3, 5'd3, 32'h9A, 4'b0001);
    check("coll_rdfirst_a", {24'b0, rdata_a}, 32'h55);
    check("coll_wrfirst_d", {24'b0, rdata_d}, 32'h9A);
    idle();
    check("coll_wrfirst_b", {24'b0, rdata_b}, 32'h9A);
    check("coll_rdfirst_c", rdata_c, 32'h55);
    op(1'b0, 1'b1, 5'd0, 5'd3, 32'd0, 4'd0);
    check("coll_after_a", {24'b0, rdata_a}, 32'h9A);
    idle();
    check("coll_after_b", {24'b0, rdata_b}, 32'h9A);

    // Out-of-range accesses on the 20-word instances
    op(1'b1, 1'b0, 5'd25, 5'd0, 32'h77, 4'b1111);
    check("oob_wr_err_d", 32'(err_d), 32'd1);
    check("oob_wr_novalid_d", 32'(rvalid_d), 32'd0);
    idle();
    check("oob_wr_err_d_clr", 32'(err_d), 32'd0);
    check("oob_wr_err_c_lat2", 32'(err_c), 32'd1);
    op(1'b0, 1'b1, 5'd0, 5'd25, 32'd0, 4'd0);
    check("oob_rd_data_d", {24'b0, rdata_d}, 32'd0);
    check("oob_rd_valid_d", 32'(rvalid_d), 32'd1);
    check("oob_rd_err_d", 32'(err_d), 32'd1);
    check("inrange_rd_a_25", {24'b0, rdata_a}, 32'h77);
    op(1'b1, 1'b1, 5'd26, 5'd27, 32'h12, 4'b1111);
    check("oob_both_err_d", 32'(err_d), 32'd1);
    idle();
    check("oob_both_single_pulse", 32'(err_d), 32'd0);

    // Global enable low blocks both ports
    enb = 1'b0;
    op(1'b1, 1'b1, 5'd3, 5'd3, 32'hEE, 4'b1111);
    check("enb_low_novalid", 32'(rvalid_a), 32'd0);
    enb = 1'b1;
    op(1'b0, 1'b1, 5'd0, 5'd3, 32'd0, 4'd0);
    check("enb_low_mem_held", {24'b0, rdata_a}, 32'h9A);

    // Read during clear, then reset mid-clear
    rst = 1'b0; idle(); rst = 1'b1;
    op(1'b0, 1'b1, 5'd0, 5'd3, 32'd0, 4'd0);
    check("rd_in_clear_novalid", 32'(rvalid_a), 32'd0);
    repeat (8) idle();
    rst = 1'b0; idle(); rst = 1'b1;
    count_busy(na, nc);
    check("busy_restart_32", na, 32);

    // Read in flight on the two-stage instance is discarded by reset
    op(1'b0, 1'b1, 5'd0, 5'd3, 32'd0, 4'd0);
    rst = 1'b0; idle();
    check("inflight_dropped_b", 32'(rvalid_b), 32'd0);
    rst = 1'b1;
    count_busy(na, nc);
    check("busy_after_inflight", na, 32);
    op(1'b0, 1'b1, 5'd0, 5'd3, 32'd0, 4'd0);
    check("cleared_after_reset", {24'b0, rdata_a}, 32'd0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
